draw_player: RTL and testbench
==============================

# draw_player

Pipeline stage in the VGA chain that overlays one playable figure on the incoming pixel stream. It latches the figure position once per frame and computes the figure-ROM address for every pixel. It takes the ROM's registered colour one cycle later and replaces the background colour inside the figure rectangle. All timing signals are delayed to stay aligned with the colour. Sits between the background/level drawing stage (upstream) and the figure colour ROM plus VGA output register (downstream).

## Interface
- FIG_WIDTH, 26, figure width in pixels
- FIG_HEIGHT, 26, figure height in pixels; FIG_WIDTH*FIG_HEIGHT ≤ 4096
- KEY_COLOR, 12'hF0F, transparent colour code in ROM data
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- vcount_in, hcount_in  in  11 each  current pixel coordinates
- vsync_in, vblnk_in, hsync_in, hblnk_in  in  1 each  timing flags
- rgb_in  in  12  background colour
- xpos, ypos  in  12 each  figure top-left corner, screen coordinates
- pixel_addr  out  12  figure-ROM address, row-major: row*FIG_WIDTH+col
- rgb_pixel  in  12  ROM data, registered by ROM one clk after pixel_addr
- vcount_out, hcount_out  out  11 each  delayed coordinates
- vsync_out, vblnk_out, hsync_out, hblnk_out  out  1 each  delayed flags
- rgb_out  out  12  composited colour

## Operation
- Position latch:
  - xpos_l/ypos_l load xpos/ypos on the rising edge of vblnk_in (vblnk_in=1 while the registered previous value is 0).
  - Otherwise they hold.
  - The position never changes mid-frame.
- In-figure test:
  - Uses hcount_in/vcount_in against the latched position.
  - The test is hcount_in ≥ xpos_l, hcount_in < xpos_l+FIG_WIDTH, and the same for vcount_in/ypos_l/FIG_HEIGHT.
  - Also requires !hblnk_in && !vblnk_in.
  - Sums are computed in 13 bits, so there is no wrap-around.
  - A figure partly past the screen edge is clipped. A figure entirely off-screen draws nothing.
- Address: inside the figure, (vcount_in−ypos_l)*FIG_WIDTH + (hcount_in−xpos_l). Outside, 0.
- Pipeline, 3 stages:
  - S1 registers pixel_addr, the in-figure flag and all timing/rgb inputs.
  - S2 delays the flag, timing and rgb while the ROM responds.
  - S3 registers the outputs: rgb_out = rgb_pixel if flag_s2, else rgb_s2.
- No state machine beyond the latch edge detector.
- No backpressure: one pixel accepted every clk.

## Timing
- Latency: 3 clk for every output relative to its input. pixel_addr appears 1 clk after inputs.
- Reset (async assert, sync-to-clk deassert handled upstream):
  - all outputs 0: pixel_addr=0, rgb_out=12'h000, all counts and flags 0
  - xpos_l=ypos_l=0
  - vblnk edge register 0
- Reset mid-frame:
  - Pipeline contents are discarded.
  - The first valid outputs appear 3 clk after the first post-reset clk edge.
  - The position stays 0 until the next vblnk rising edge.
- If xpos/ypos change in the same clk as the vblnk rising edge, the new value is latched.
- vblnk_in held at 1 from reset: no edge is detected and the position remains 0.

## Configuration
- FIGURE_TRANSPARENCY_EN defined: inside the figure, when rgb_pixel == KEY_COLOR, rgb_out = background (rgb_s2). This gives a non-rectangular silhouette.
- Not defined: the whole FIG_WIDTH×FIG_HEIGHT rectangle is overwritten by ROM data, KEY_COLOR included. KEY_COLOR is unused.

## Test plan
- Reset with rst_n=0 mid-line → all outputs 0 immediately (async). After release, hcount_out tracks hcount_in delayed by exactly 3 clk.
- xpos=100, ypos=50 latched at vblnk; ROM model returns 12'h0F0:
  - pixel (100,50) → pixel_addr=0, rgb_out=12'h0F0
  - (125,75) → pixel_addr=675
  - (126,50) and (99,50) → rgb_out=rgb_in
- xpos changed from 100 to 200 mid-frame (no vblnk edge) → the rest of the frame is still drawn at x=100. The next frame is drawn at x=200.
- xpos=790, ypos=590 on an 800×600 screen → only columns 790–799 and rows 590–599 are drawn. pixel_addr at (799,599)=9*26+9=243. No drawing during blanking.
- With FIGURE_TRANSPARENCY_EN, ROM returns 12'hF0F at one in-figure pixel → rgb_out=rgb_in there. Without the macro → rgb_out=12'hF0F.
- xpos=4000 → in-figure flag never set, pixel_addr stays 0, rgb_out==rgb_in delayed 3 clk for the whole frame.

Source files
------------

// File: rtl/draw_player.sv
// draw_player: overlays a ROM figure on the pixel stream with 3-clk aligned timing.
// Optional FIGURE_TRANSPARENCY_EN: ROM pixels equal to KEY_COLOR show the background.
module draw_player #(
  parameter int          FIG_WIDTH  = 26,
  parameter int          FIG_HEIGHT = 26,
  parameter logic [11:0] KEY_COLOR  = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] vcount_in,
  input  logic [10:0] hcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [11:0] pixel_addr,
  input  logic [11:0] rgb_pixel,
  output logic [10:0] vcount_out,
  output logic [10:0] hcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out
);
  logic [11:0] xpos_l, ypos_l;
  logic        vblnk_prev, armed;
  // armed keeps a vblnk held high through reset from counting as a rising edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      xpos_l     <= '0;
      ypos_l     <= '0;
      vblnk_prev <= 1'b0;
      armed      <= 1'b0;
    end else begin
      vblnk_prev <= vblnk_in;
      armed      <= 1'b1;
      if (armed && vblnk_in && !vblnk_prev) begin
        xpos_l <= xpos;
        ypos_l <= ypos;
      end
    end
  logic [12:0] h13, v13, x13, y13, dx, dy;
  logic        in_fig;
  logic [11:0] addr_c;
  assign h13    = {2'b00, hcount_in};
  assign v13    = {2'b00, vcount_in};
  assign x13    = {1'b0, xpos_l};
  assign y13    = {1'b0, ypos_l};
  assign dx     = h13 - x13;
  assign dy     = v13 - y13;
  assign in_fig = !hblnk_in && !vblnk_in &&
                  h13 >= x13 && h13 < x13 + 13'(FIG_WIDTH) &&
                  v13 >= y13 && v13 < y13 + 13'(FIG_HEIGHT);
  assign addr_c = in_fig ? 12'(dy * 13'(FIG_WIDTH) + dx) : 12'd0;
  logic [25:0] t_in, t_s1, t_s2;
  logic [11:0] rgb_s1, rgb_s2;
  logic        flag_s1, flag_s2, use_rom;
  assign t_in = {vcount_in, hcount_in, vsync_in, vblnk_in, hsync_in, hblnk_in};
`ifdef FIGURE_TRANSPARENCY_EN
  assign use_rom = flag_s2 && rgb_pixel != KEY_COLOR;
`else
  logic [11:0] unused_key;
  assign unused_key = KEY_COLOR;
  assign use_rom    = flag_s2;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pixel_addr <= '0;
      flag_s1    <= 1'b0;
      flag_s2    <= 1'b0;
      t_s1       <= '0;
      t_s2       <= '0;
      rgb_s1     <= '0;
      rgb_s2     <= '0;
      {vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out} <= '0;
      rgb_out    <= '0;
    end else begin
      pixel_addr <= addr_c;
      flag_s1    <= in_fig;
      t_s1       <= t_in;
      rgb_s1     <= rgb_in;
      flag_s2    <= flag_s1;
      t_s2       <= t_s1;
      rgb_s2     <= rgb_s1;
      {vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out} <= t_s2;
      rgb_out    <= use_rom ? rgb_pixel : rgb_s2;
    end
endmodule

// File: tb/tb_draw_player.sv
// tb_draw_player: randomized and directed checks of draw_player against a frame-level model.
module tb_draw_player;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] vcount_in, hcount_in, vcount_out, hcount_out;
  logic        vsync_in, vblnk_in, hsync_in, hblnk_in;
  logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
  logic [11:0] rgb_in, xpos, ypos, pixel_addr, rgb_pixel, rgb_out;
  int n_cmp = 0, n_err = 0;
  bit          rom_const = 1'b1;
  logic [11:0] rom_val = 12'h0F0;
  int  mx, my;
  bit  m_prev;
  typedef struct {
    logic [10:0] h, v;
    logic [3:0]  fl;
    logic [11:0] rgb;
  } rec_t;
  rec_t q[$];

  draw_player dut (
    .clk(clk), .rst_n(rst_n), .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .vblnk_in(vblnk_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .pixel_addr(pixel_addr),
    .rgb_pixel(rgb_pixel), .vcount_out(vcount_out), .hcount_out(hcount_out),
    .vsync_out(vsync_out), .vblnk_out(vblnk_out), .hsync_out(hsync_out),
    .hblnk_out(hblnk_out), .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_f(input logic [11:0] a);
    return rom_const ? rom_val : (a ^ 12'hA5C);
  endfunction

  always @(posedge clk) rgb_pixel <= rom_f(pixel_addr);

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
    $fatal(1);
  end

  // Model state after reset: position at origin, no vblnk edge until vblnk is seen low first
  task automatic model_reset();
    mx = 0;
    my = 0;
    m_prev = 1'b1;
    q.delete();
  endtask

  task automatic step(input int h, input int v, input bit hb, input bit vb, input logic [11:0] rgb);
    rec_t r;
    bit   fig;
    int   addr;
    logic [11:0] pix;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = hb;
    vblnk_in  = vb;
    hsync_in  = 1'($urandom);
    vsync_in  = 1'($urandom);
    rgb_in    = rgb;
    fig  = !hb && !vb && h >= mx && h < mx + 26 && v >= my && v < my + 26;
    addr = fig ? (v - my) * 26 + (h - mx) : 0;
    pix  = rom_f(12'(addr));
    r.h = hcount_in;
    r.v = vcount_in;
    r.fl = {vsync_in, vblnk_in, hsync_in, hblnk_in};
`ifdef FIGURE_TRANSPARENCY_EN
    r.rgb = (fig && pix != 12'hF0F) ? pix : rgb;
`else
    r.rgb = fig ? pix : rgb;
`endif
    q.push_back(r);
    if (vb && !m_prev) begin
      mx = int'(xpos);
      my = int'(ypos);
    end
    m_prev = vb;
    @(posedge clk);
    #1;
    n_cmp++;
    if (pixel_addr !== 12'(addr)) begin
      n_err++;
      $display("FAIL addr at (%0d,%0d): got %0d required %0d", h, v, pixel_addr, addr);
    end
    if (q.size() == 3) begin
      r = q.pop_front();
      n_cmp++;
      if ({hcount_out, vcount_out} !== {r.h, r.v}) begin
        n_err++;
        $display("FAIL counts: got h=%0d v=%0d required h=%0d v=%0d", hcount_out, vcount_out, r.h, r.v);
      end
      n_cmp++;
      if ({vsync_out, vblnk_out, hsync_out, hblnk_out} !== r.fl) begin
        n_err++;
        $display("FAIL flags at (%0d,%0d): got %b required %b", r.h, r.v,
                 {vsync_out, vblnk_out, hsync_out, hblnk_out}, r.fl);
      end
      n_cmp++;
      if (rgb_out !== r.rgb) begin
        n_err++;
        $display("FAIL rgb at (%0d,%0d): got %h required %h", r.h, r.v, rgb_out, r.rgb);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(900, 700, 1'b1, 1'b0, 12'($urandom));
  endtask

  task automatic vblank(input int x, input int y);
    idle(1);
    xpos = 12'(x);
    ypos = 12'(y);
    for (int i = 0; i < 3; i++) step(900, 650, 1'b1, 1'b1, 12'($urandom));
    idle(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {hcount_in, vcount_in, hblnk_in, vblnk_in, hsync_in, vsync_in} = '0;
    rgb_in = 12'h123;
    xpos = 12'd300;
    ypos = 12'd10;
    #1;
    n_cmp++;
    if ({pixel_addr, rgb_out, hcount_out, vcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out} !== '0) begin
      n_err++;
      $display("FAIL reset_init: outputs not all zero, addr=%0d rgb=%h h=%0d", pixel_addr, rgb_out, hcount_out);
    end
    #11;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) step(310, 20, 1'b0, 1'b1, 12'($urandom));
    for (int i = 0; i < 8; i++) step(i, 5, 1'b0, 1'b0, 12'($urandom));
    for (int i = 0; i < 8; i++) step(300 + i, 12, 1'b0, 1'b0, 12'($urandom));
    n_cmp++;
    if (hcount_out !== 11'd305) begin
      n_err++;
      $display("FAIL reset_latency: hcount_out got %0d required 305", hcount_out);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({pixel_addr, rgb_out, hcount_out, vcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out} !== '0) begin
      n_err++;
      $display("FAIL reset_async: outputs not all zero, addr=%0d rgb=%h h=%0d v=%0d", pixel_addr, rgb_out, hcount_out, vcount_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) step(20 + i, 3, 1'b0, 1'b0, 12'($urandom));
  endtask

  task automatic test_basic();
    logic [11:0] bg;
    rom_const = 1'b1;
    rom_val = 12'h0F0;
    vblank(100, 50);
    step(100, 50, 1'b0, 1'b0, 12'h111);
    n_cmp++;
    if (pixel_addr !== 12'd0) begin
      n_err++;
      $display("FAIL basic_origin: addr got %0d required 0", pixel_addr);
    end
    step(125, 75, 1'b0, 1'b0, 12'h222);
    n_cmp++;
    if (pixel_addr !== 12'd675) begin
      n_err++;
      $display("FAIL basic_corner: addr got %0d required 675", pixel_addr);
    end
    bg = 12'h3C5;
    step(126, 50, 1'b0, 1'b0, bg);
    step(99, 50, 1'b0, 1'b0, 12'h456);
    step(100, 50, 1'b0, 1'b0, 12'h789);
    n_cmp++;
    if (rgb_out !== bg) begin
      n_err++;
      $display("FAIL basic_right_edge: rgb got %h required %h", rgb_out, bg);
    end
    for (int h = 95; h < 130; h++) step(h, 60, 1'b0, 1'b0, 12'($urandom));
    idle(3);
  endtask

  task automatic test_midframe();
    rom_const = 1'b0;
    vblank(100, 50);
    for (int v = 50; v < 53; v++) for (int h = 90; h < 136; h++) step(h, v, 1'b0, 1'b0, 12'($urandom));
    xpos = 12'd200;
    step(100, 53, 1'b0, 1'b0, 12'($urandom));
    n_cmp++;
    if (pixel_addr !== 12'd78) begin
      n_err++;
      $display("FAIL midframe_hold: addr got %0d required 78", pixel_addr);
    end
    for (int h = 190; h < 236; h++) step(h, 54, 1'b0, 1'b0, 12'($urandom));
    vblank(200, 50);
    step(200, 60, 1'b0, 1'b0, 12'($urandom));
    n_cmp++;
    if (pixel_addr !== 12'd260) begin
      n_err++;
      $display("FAIL midframe_next: addr got %0d required 260", pixel_addr);
    end
    for (int h = 90; h < 236; h++) step(h, 61, 1'b0, 1'b0, 12'($urandom));
    idle(3);
  endtask

  task automatic test_clip();
    rom_const = 1'b0;
    vblank(790, 590);
    for (int v = 586; v < 600; v++) for (int h = 786; h < 806; h++) step(h, v, h >= 800, 1'b0, 12'($urandom));
    step(799, 599, 1'b0, 1'b0, 12'($urandom));
    n_cmp++;
    if (pixel_addr !== 12'd243) begin
      n_err++;
      $display("FAIL clip_corner: addr got %0d required 243", pixel_addr);
    end
    for (int h = 788; h < 806; h++) step(h, 600, 1'b0, 1'b1, 12'($urandom));
    idle(3);
  endtask

  task automatic test_offscreen();
    rom_const = 1'b0;
    vblank(4000, 100);
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(2047), $urandom_range(2047), 1'($urandom_range(3) == 0), 1'b0, 12'($urandom));
      n_cmp++;
      if (pixel_addr !== 12'd0) begin
        n_err++;
        $display("FAIL offscreen: addr got %0d required 0", pixel_addr);
      end
    end
    idle(3);
  endtask

  task automatic test_transparency();
    logic [11:0] bg, want;
    rom_const = 1'b1;
    rom_val = 12'hF0F;
    vblank(10, 10);
    bg = 12'h5A7;
    step(15, 15, 1'b0, 1'b0, bg);
    idle(2);
`ifdef FIGURE_TRANSPARENCY_EN
    want = bg;
`else
    want = 12'hF0F;
`endif
    n_cmp++;
    if (rgb_out !== want) begin
      n_err++;
      $display("FAIL key_color: rgb got %h required %h", rgb_out, want);
    end
    idle(3);
  endtask

  task automatic test_random();
    bit vb = 1'b0;
    rom_const = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(30) == 0) vb = !vb;
      if ($urandom_range(10) == 0) begin
        xpos = 12'($urandom_range(830));
        ypos = 12'($urandom_range(630));
      end
      step(mx - 4 + int'($urandom_range(34)), my - 4 + int'($urandom_range(34)),
           1'($urandom_range(9) == 0), vb, 12'($urandom));
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midframe();
    test_clip();
    test_offscreen();
    test_transparency();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
